// File: rtl/rv32i_pkg.sv
// Shared constants and writeback request bundle for the RV32I register-file writeback path.
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way writeback arbiter: round-robin pointer by default, or fixed priority
// to requester 1 when WB_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef WB_ARB_FIXED_PRIO_EN
    // The load/CSR unit always wins a conflict.
    always_comb begin
        gnt[1] = req[1];
        gnt[0] = req[0] && !req[1];
    end
`else
    logic ptr;  // 0: requester 0 wins a conflict, 1: requester 1 wins

    // NOTE: assign defaults first so every path drives gnt and no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !ptr))
            gnt[0] = 1'b1;
        else if (req[1])
            gnt[1] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= 1'b0;
        else if (gnt[0])
            ptr <= 1'b1;
        else if (gnt[1])
            ptr <= 1'b0;
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with registered write outputs and a busy scoreboard.
// Conflict policy is selected by WB_ARB_FIXED_PRIO_EN (see rr_arb2).
module regfile_wb_arbiter
    import rv32i_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [REG_AW-1:0] req0_rd,
    input  logic [XLEN-1:0]   req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [REG_AW-1:0] req1_rd,
    input  logic [XLEN-1:0]   req1_data,
    output logic              req1_ready,
    input  logic              rsv_valid,
    input  logic [REG_AW-1:0] rsv_rd,
    output logic [NREG-1:0]   busy,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   wrs3,
    output logic              we
);

    wb_req_t          req0, req1, sel;
    logic [1:0]       gnt;
    logic             xfer;
    logic [NREG-1:1]  busy_q, busy_next;

    assign req0 = '{valid: req0_valid, rd: req0_rd, data: req0_data};
    assign req1 = '{valid: req1_valid, rd: req1_rd, data: req1_data};

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req1.valid, req0.valid}),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign xfer       = |gnt;
    assign sel        = gnt[1] ? req1 : req0;

    // x0 writes are accepted but never reach the regfile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we   <= 1'b0;
            rd   <= '0;
            wrs3 <= '0;
        end else begin
            we <= xfer && (sel.rd != REG_ZERO);
            if (xfer) begin
                rd   <= sel.rd;
                wrs3 <= sel.data;
            end
        end
    end

    // A reservation and a retiring write to the same register leave it busy.
    always_comb begin
        busy_next = busy_q;
        for (int i = 1; i < NREG; i++) begin
            busy_next[i] = (rsv_valid && rsv_rd == REG_AW'(i))
                        || (busy_q[i] && !(we && rd == REG_AW'(i)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy_q <= '0;
        else
            busy_q <= busy_next;
    end

    assign busy = {busy_q, 1'b0};

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (rd, wrs3, we) between two writeback requesters. Requester 0 is the execute/ALU writeback; requester 1 is the multi-cycle load/CSR unit.
- Keeps a per-register busy scoreboard. Issue logic uses it to stall reads of registers with pending writes.
- Sits between the execution units and the regfile. It drives regfile write inputs directly from registered outputs.

Parameters:
- XLEN, 32, data width of write data.
- REG_AW, 5, register address width.
- NREG, 32, number of architectural registers (2**REG_AW).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req0_valid  input  1  requester 0 has a write pending.
- req0_rd  input  REG_AW  requester 0 destination register.
- req0_data  input  XLEN  requester 0 write data.
- req0_ready  output  1  requester 0 granted this cycle.
- req1_valid  input  1  requester 1 has a write pending.
- req1_rd  input  REG_AW  requester 1 destination register.
- req1_data  input  XLEN  requester 1 write data.
- req1_ready  output  1  requester 1 granted this cycle.
- rsv_valid  input  1  issue logic reserves a destination register.
- rsv_rd  input  REG_AW  register being reserved.
- busy  output  NREG  scoreboard; bit i=1 means a write to xi is pending.
- rd  output  REG_AW  to regfile write address.
- wrs3  output  XLEN  to regfile write data.
- we  output  1  to regfile write enable.

Behaviour:
- Reset (reset=0, asynchronous): we=0, rd=0, wrs3=0, busy=0. Grant pointer set to prefer requester 0.
- Handshake: a transfer occurs when reqN_valid && reqN_ready.
  - reqN_ready is combinational from the valids and the grant pointer. At most one ready is high per cycle.
  - A requester must hold valid/rd/data stable until its ready is seen.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the pointer decides. After a grant, the pointer moves to the other requester (round-robin).
  - Pointer is unchanged on cycles with no grant.
- Latency: a transfer in cycle N drives we=1, rd, wrs3 during cycle N+1, and the regfile samples them at the end of N+1. we=0 in any cycle following a cycle with no transfer.
  - Throughput is one write per cycle. There is no back-pressure from the regfile.
- x0:
  - A transfer with rd=0 is accepted (ready asserted) but produces we=0 in N+1; rd/wrs3 still update.
  - rsv_rd=0 never sets busy[0]. busy[0] is constant 0.
- Scoreboard:
  - rsv_valid sets busy[rsv_rd] at the next clock edge.
  - busy[rd] clears at the clock edge that ends a cycle with we=1.
  - Set and clear of the same register on the same edge: set wins (busy stays 1).
  - Reserving an already-busy register: stays 1. There is no counting; issue logic must not double-reserve.
  - Clearing an already-clear bit: no effect.
- Reset mid-operation: any registered write in flight is dropped (we forced 0 immediately). Scoreboard is cleared. Requesters must re-present after reset release.

Optional Feature:
- Macro: WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 1 (load/CSR) always wins when both are valid; the grant pointer is removed.
- Undefined: round-robin as described above.

Decomposition:
- Shared package rv32i_pkg holds:
  - constants XLEN=32, REG_AW=5, NREG=32, REG_ZERO=0;
  - a wb_req typedef bundling valid/rd/data.
- One sub-module: rr_arb2, the 2-way arbiter with pointer.
  - Inputs: req[1:0]. Outputs: gnt[1:0] one-hot.
  - Contains the pointer register and the fixed-priority alternative under the macro.
- Top module holds the output register and scoreboard.

Test Plan:
- Reset, then req0 only: valid=1, rd=3, data=16 at cycle N → req0_ready=1 at N; at N+1 we=1, rd=3, wrs3=16; every later cycle we=0.
- Contention, round-robin: both valid every cycle, req0 rd=5/data=0xAAAA, req1 rd=6/data=0x5555 → grants alternate 0,1,0,1; we=1 every cycle with rd 5,6,5,6.
  - With WB_ARB_FIXED_PRIO_EN defined: req1 granted every cycle and req0_ready stays 0.
- x0 suppression: req0 rd=0, data=0xDEAD → ready=1, we=0 next cycle; rsv_valid with rsv_rd=0 → busy stays 0.
- Scoreboard: rsv x7 → busy[7]=1; req1 writes x7 → busy[7]=0 at the edge ending the we cycle.
  - Collision: rsv x7 in the same cycle as the x7 write (we=1) → busy[7] remains 1.
- Async reset mid-flight: assert reset=0 between clock edges while we=1 and busy=0x0000_0088 → we=0 and busy=0 immediately, before the next edge.
  - After release, a new req0 write (rd=1, data=1) completes normally.
